// File: rtl/mem_pkg.sv
// Shared memory-access encodings: mem_op values, FSM states and access sizing.
// The decoder uses the same MEM_OP_* constants so both sides agree on the encoding.
package mem_pkg;

    localparam logic [2:0] MEM_OP_WORD = 3'b000;
    localparam logic [2:0] MEM_OP_SH   = 3'b001;
    localparam logic [2:0] MEM_OP_SB   = 3'b010;
    localparam logic [2:0] MEM_OP_LH   = 3'b100;
    localparam logic [2:0] MEM_OP_LHU  = 3'b101;
    localparam logic [2:0] MEM_OP_LB   = 3'b110;
    localparam logic [2:0] MEM_OP_LBU  = 3'b111;

    localparam int TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } mem_size_t;

    // Any encoding that is not a recognised sub-word op for this direction is a word access.
    function automatic mem_size_t access_size(input logic [2:0] op, input logic we);
        mem_size_t size;
        size = SZ_WORD;
        if (we) begin
            case (op)
                MEM_OP_SH: size = SZ_HALF;
                MEM_OP_SB: size = SZ_BYTE;
                default:   size = SZ_WORD;
            endcase
        end else begin
            case (op)
                MEM_OP_LH, MEM_OP_LHU: size = SZ_HALF;
                MEM_OP_LB, MEM_OP_LBU: size = SZ_BYTE;
                default:               size = SZ_WORD;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Single-port data bus between the access controller (master) and data memory (slave).
interface mem_access_ctrl_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane logic: alignment check, store strobes/replication and load extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    mem_size_t  size;
    logic       sign_ext;
    logic [7:0] byte_lane;
    logic [15:0] half_lane;

    assign size     = access_size(op, we);
    assign sign_ext = ~op[0];

    always_comb begin
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        misaligned = 1'b0;
        wstrb      = 4'b0000;
        wdata_rep  = 32'h0;
        rdata_ext  = rdata;
        case (size)
            SZ_BYTE: begin
                if (we) begin
                    wstrb     = 4'b0001 << addr_lo;
                    wdata_rep = {4{wdata[7:0]}};
                end
                rdata_ext = sign_ext ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
            end
            SZ_HALF: begin
                misaligned = addr_lo[0];
                if (we) begin
                    wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata_rep = {2{wdata[15:0]}};
                end
                rdata_ext = sign_ext ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
                if (we) begin
                    wstrb     = 4'b1111;
                    wdata_rep = wdata;
                end
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: latches the access, drives one bus cycle, stalls
// the pipeline until ack or timeout and returns extended data or an error for one cycle.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_mem_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err_ld,
    output logic        addr_err_st,
    output logic        bus_err,
    output logic [31:0] bad_vaddr,
    mem_access_ctrl_if.master bus
);

    localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(TIMEOUT - 1);

    mem_state_t            state;
    logic                  lat_we;
    logic [2:0]            lat_op;
    logic [31:0]           lat_addr;
    logic [TIMEOUT_W-1:0]  wait_cnt;

    logic                  bus_req_q;
    logic                  bus_we_q;
    logic [31:0]           bus_addr_q;
    logic [3:0]            bus_wstrb_q;
    logic [31:0]           bus_wdata_q;

    logic                  idle;
    logic                  lane_we;
    logic [2:0]            lane_op;
    logic [1:0]            lane_addr_lo;
    logic                  lane_misaligned;
    logic [3:0]            lane_wstrb;
    logic [31:0]           lane_wdata;
    logic [31:0]           lane_rdata;

    // In IDLE the lane logic sees the incoming request; afterwards only the latched copy.
    assign idle         = (state == ST_IDLE);
    assign lane_we      = idle ? req_we : lat_we;
    assign lane_op      = idle ? req_mem_op : lat_op;
    assign lane_addr_lo = idle ? req_addr[1:0] : lat_addr[1:0];

    mem_lane_align u_lane (
        .op         (lane_op),
        .we         (lane_we),
        .addr_lo    (lane_addr_lo),
        .wdata      (req_wdata),
        .rdata      (bus.bus_rdata),
        .misaligned (lane_misaligned),
        .wstrb      (lane_wstrb),
        .wdata_rep  (lane_wdata),
        .rdata_ext  (lane_rdata)
    );

    assign stall = (idle && req_valid) || (state == ST_REQ);

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wstrb = bus_wstrb_q;
    assign bus.bus_wdata = bus_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            lat_we      <= 1'b0;
            lat_op      <= 3'b000;
            lat_addr    <= 32'h0;
            wait_cnt    <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wstrb_q <= 4'b0000;
            bus_wdata_q <= 32'h0;
            done        <= 1'b0;
            rdata       <= 32'h0;
            addr_err_ld <= 1'b0;
            addr_err_st <= 1'b0;
            bus_err     <= 1'b0;
            bad_vaddr   <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we   <= req_we;
                        lat_op   <= req_mem_op;
                        lat_addr <= req_addr;
                        wait_cnt <= '0;
                        if (lane_misaligned) begin
                            state       <= ST_DONE;
                            done        <= 1'b1;
                            addr_err_ld <= ~req_we;
                            addr_err_st <= req_we;
                            bad_vaddr   <= req_addr;
                        end else begin
                            state       <= ST_REQ;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= req_we;
                            bus_addr_q  <= {req_addr[31:2], 2'b00};
                            bus_wstrb_q <= lane_wstrb;
                            bus_wdata_q <= lane_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack wins over timeout when both land in the last wait cycle.
                    if (bus.bus_ack) begin
                        state       <= ST_DONE;
                        done        <= 1'b1;
                        rdata       <= lat_we ? 32'h0 : lane_rdata;
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= 32'h0;
                        bus_wstrb_q <= 4'b0000;
                        bus_wdata_q <= 32'h0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state       <= ST_DONE;
                        done        <= 1'b1;
                        bus_err     <= 1'b1;
                        bad_vaddr   <= lat_addr;
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= 32'h0;
                        bus_wstrb_q <= 4'b0000;
                        bus_wdata_q <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + TIMEOUT_W'(1);
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    wait_cnt    <= '0;
                    done        <= 1'b0;
                    rdata       <= 32'h0;
                    addr_err_ld <= 1'b0;
                    addr_err_st <= 1'b0;
                    bus_err     <= 1'b0;
                    bad_vaddr   <= 32'h0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT=4; expected values are hand-computed.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_mem_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        addr_err_ld;
    logic        addr_err_st;
    logic        bus_err;
    logic [31:0] bad_vaddr;

    mem_access_ctrl_if bus_if ();

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_mem_op  (req_mem_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .done        (done),
        .rdata       (rdata),
        .addr_err_ld (addr_err_ld),
        .addr_err_st (addr_err_st),
        .bus_err     (bus_err),
        .bad_vaddr   (bad_vaddr),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int          obs_stall;
    int          obs_reqc;
    int          obs_done_idx;
    int          obs_done_cyc;
    logic        obs_done;
    logic [31:0] obs_rdata;
    logic [31:0] obs_bad;
    logic [31:0] obs_baddr;
    logic [31:0] obs_bwdata;
    logic [3:0]  obs_wstrb;
    logic        obs_bwe;
    logic        obs_eld;
    logic        obs_est;
    logic        obs_berr;

    // Issues one access and acts as the bus slave; ack_at<0 means never ack in REQ.
    // Outside REQ the slave raises a garbage ack, which the DUT has to ignore.
    task automatic run_access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, input int ack_at, input logic [31:0] word);
        obs_stall = 0; obs_reqc = 0; obs_done_idx = -1; obs_done_cyc = 0; obs_done = 1'b0;
        obs_rdata = '0; obs_bad = '0; obs_baddr = '0; obs_bwdata = '0; obs_wstrb = '0;
        obs_bwe = 1'b0; obs_eld = 1'b0; obs_est = 1'b0; obs_berr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                req_valid = 1'b1; req_we = we; req_mem_op = op; req_addr = addr; req_wdata = wd;
            end else begin
                req_we = ~we; req_mem_op = 3'b011; req_addr = 32'h0000_0F0E; req_wdata = 32'h5A5A_5A5A;
            end
            if (bus_if.bus_req) begin
                obs_reqc++;
                if (obs_reqc == 1) begin
                    obs_baddr = bus_if.bus_addr; obs_bwdata = bus_if.bus_wdata;
                    obs_wstrb = bus_if.bus_wstrb; obs_bwe = bus_if.bus_we;
                end
                bus_if.bus_ack   = (obs_reqc == ack_at);
                bus_if.bus_rdata = word;
            end else begin
                bus_if.bus_ack   = 1'b1;
                bus_if.bus_rdata = 32'hBAD0_BAD0;
            end
            @(negedge clk);
            if (stall) obs_stall++;
            if (done) begin
                obs_done = 1'b1; obs_done_idx = i; obs_done_cyc = cyc;
                obs_rdata = rdata; obs_bad = bad_vaddr;
                obs_eld = addr_err_ld; obs_est = addr_err_st; obs_berr = bus_err;
                break;
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_mem_op = 3'b000; req_addr = '0; req_wdata = '0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({stall, done, bus_if.bus_req, bus_if.bus_we, addr_err_ld, addr_err_st, bus_err} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000000",
                     {stall, done, bus_if.bus_req, bus_if.bus_we, addr_err_ld, addr_err_st, bus_err});
        end
        checks++;
        if ({rdata, bad_vaddr, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb} !== 132'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got rdata=%h bad=%h addr=%h wdata=%h wstrb=%b expected all zero",
                     rdata, bad_vaddr, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb);
        end
    endtask

    task automatic test_load_word();
        run_access(1'b0, 3'b000, 32'h0000_0100, 32'h0, 4, 32'hDEAD_BEEF);
        checks++;
        if (obs_stall !== 5) begin errors++; $display("[TB] FAIL lw_stall_cycles: got %0d expected 5", obs_stall); end
        checks++;
        if (obs_done_idx !== 5) begin errors++; $display("[TB] FAIL lw_latency: got %0d expected 5", obs_done_idx); end
        checks++;
        if (obs_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL lw_rdata: got %h expected deadbeef", obs_rdata); end
        checks++;
        if (obs_baddr !== 32'h0000_0100 || obs_wstrb !== 4'b0000 || obs_bwe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_bus: got addr=%h wstrb=%b we=%b expected 00000100 0000 0", obs_baddr, obs_wstrb, obs_bwe);
        end
        checks++;
        if (obs_reqc !== 4) begin errors++; $display("[TB] FAIL lw_req_cycles: got %0d expected 4", obs_reqc); end
        idle_cycle();
        checks++;
        if ({done, stall, bus_if.bus_req} !== 3'b000 || rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL lw_after_idle: got done/stall/req=%b rdata=%h expected 000 0", {done, stall, bus_if.bus_req}, rdata);
        end
    endtask

    task automatic test_load_subword();
        run_access(1'b0, 3'b110, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234);
        checks++;
        if (obs_rdata !== 32'hFFFF_FF80 || obs_done_idx !== 2) begin
            errors++; $display("[TB] FAIL lb_rdata: got %h idx %0d expected ffffff80 idx 2", obs_rdata, obs_done_idx);
        end
        idle_cycle();
        run_access(1'b0, 3'b111, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234);
        checks++;
        if (obs_rdata !== 32'h0000_0080) begin errors++; $display("[TB] FAIL lbu_rdata: got %h expected 00000080", obs_rdata); end
        idle_cycle();
        run_access(1'b0, 3'b100, 32'h0000_0102, 32'h0, 2, 32'h80FF_1234);
        checks++;
        if (obs_rdata !== 32'hFFFF_80FF || obs_baddr !== 32'h0000_0100) begin
            errors++; $display("[TB] FAIL lh_rdata: got %h addr %h expected ffff80ff addr 00000100", obs_rdata, obs_baddr);
        end
        idle_cycle();
        run_access(1'b0, 3'b101, 32'h0000_0100, 32'h0, 1, 32'h1234_8001);
        checks++;
        if (obs_rdata !== 32'h0000_8001) begin errors++; $display("[TB] FAIL lhu_rdata: got %h expected 00008001", obs_rdata); end
        idle_cycle();
        run_access(1'b0, 3'b110, 32'h0000_0101, 32'h0, 1, 32'h80FF_7F34);
        checks++;
        if (obs_rdata !== 32'h0000_007F) begin errors++; $display("[TB] FAIL lb_pos_rdata: got %h expected 0000007f", obs_rdata); end
        idle_cycle();
    endtask

    task automatic test_store();
        run_access(1'b1, 3'b010, 32'h0000_0201, 32'h0000_00AB, 1, 32'h0);
        checks++;
        if (obs_baddr !== 32'h0000_0200 || obs_wstrb !== 4'b0010 || obs_bwdata !== 32'hABAB_ABAB || obs_bwe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sb_bus: got addr=%h wstrb=%b wdata=%h we=%b expected 00000200 0010 abababab 1",
                     obs_baddr, obs_wstrb, obs_bwdata, obs_bwe);
        end
        checks++;
        if (obs_done !== 1'b1 || obs_done_idx !== 2) begin errors++; $display("[TB] FAIL sb_done: got %b idx %0d expected 1 idx 2", obs_done, obs_done_idx); end
        idle_cycle();
        run_access(1'b1, 3'b001, 32'h0000_0202, 32'h1234_CDEF, 1, 32'h0);
        checks++;
        if (obs_wstrb !== 4'b1100 || obs_bwdata !== 32'hCDEF_CDEF) begin
            errors++; $display("[TB] FAIL sh_bus: got wstrb=%b wdata=%h expected 1100 cdefcdef", obs_wstrb, obs_bwdata);
        end
        idle_cycle();
        run_access(1'b1, 3'b011, 32'h0000_0204, 32'h1122_3344, 1, 32'h0);
        checks++;
        if (obs_wstrb !== 4'b1111 || obs_bwdata !== 32'h1122_3344 || obs_baddr !== 32'h0000_0204) begin
            errors++; $display("[TB] FAIL unknown_op_store: got wstrb=%b wdata=%h addr=%h expected 1111 11223344 00000204",
                               obs_wstrb, obs_bwdata, obs_baddr);
        end
        idle_cycle();
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 3'b000, 32'h0000_0102, 32'h0, 1, 32'h0);
        checks++;
        if (obs_reqc !== 0 || obs_done_idx !== 1) begin
            errors++; $display("[TB] FAIL lw_mis_nobus: got reqc=%0d idx=%0d expected 0 1", obs_reqc, obs_done_idx);
        end
        checks++;
        if (obs_eld !== 1'b1 || obs_est !== 1'b0 || obs_bad !== 32'h0000_0102) begin
            errors++; $display("[TB] FAIL lw_mis_err: got ld=%b st=%b bad=%h expected 1 0 00000102", obs_eld, obs_est, obs_bad);
        end
        idle_cycle();
        run_access(1'b1, 3'b001, 32'h0000_0301, 32'hFFFF_FFFF, 1, 32'h0);
        checks++;
        if (obs_est !== 1'b1 || obs_eld !== 1'b0 || obs_bad !== 32'h0000_0301 || obs_reqc !== 0) begin
            errors++; $display("[TB] FAIL sh_mis_err: got st=%b ld=%b bad=%h reqc=%0d expected 1 0 00000301 0",
                               obs_est, obs_eld, obs_bad, obs_reqc);
        end
        idle_cycle();
    endtask

    task automatic test_timeout();
        run_access(1'b0, 3'b000, 32'h0000_0500, 32'h0, -1, 32'h0);
        checks++;
        if (obs_berr !== 1'b1 || obs_done_idx !== 5 || obs_reqc !== 4) begin
            errors++; $display("[TB] FAIL timeout_err: got berr=%b idx=%0d reqc=%0d expected 1 5 4", obs_berr, obs_done_idx, obs_reqc);
        end
        checks++;
        if (obs_bad !== 32'h0000_0500 || obs_rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL timeout_bad: got bad=%h rdata=%h expected 00000500 0", obs_bad, obs_rdata);
        end
        idle_cycle();
        checks++;
        if ({bus_if.bus_req, stall, done, bus_err} !== 4'b0000) begin
            errors++; $display("[TB] FAIL timeout_idle: got req/stall/done/berr=%b expected 0000", {bus_if.bus_req, stall, done, bus_err});
        end
    endtask

    task automatic test_back_to_back();
        int first_cyc;
        run_access(1'b0, 3'b000, 32'h0000_0600, 32'h0, 1, 32'h0102_0304);
        first_cyc = obs_done_cyc;
        checks++;
        if (obs_rdata !== 32'h0102_0304) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 01020304", obs_rdata); end
        run_access(1'b1, 3'b000, 32'h0000_0604, 32'hCAFE_F00D, 1, 32'h0);
        checks++;
        if (obs_done_cyc - first_cyc !== 3 || obs_bwdata !== 32'hCAFE_F00D || obs_baddr !== 32'h0000_0604) begin
            errors++; $display("[TB] FAIL b2b_second: got gap=%0d wdata=%h addr=%h expected 3 cafef00d 00000604",
                               obs_done_cyc - first_cyc, obs_bwdata, obs_baddr);
        end
        idle_cycle();
    endtask

    task automatic test_reset_in_req();
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_mem_op = 3'b000; req_addr = 32'h0000_0400;
        bus_if.bus_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus_if.bus_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_req_entered: got %b expected 1", bus_if.bus_req); end
        rst = 1'b1; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1234_5678; req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
        @(negedge clk);
        checks++;
        if ({stall, done, bus_if.bus_req, bus_err} !== 4'b0000 || rdata !== 32'h0 || bus_if.bus_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL rst_in_req: got stall/done/req/berr=%b rdata=%h addr=%h expected 0000 0 0",
                               {stall, done, bus_if.bus_req, bus_err}, rdata, bus_if.bus_addr);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_no_done: got done=%b rdata=%h expected 0 0", done, rdata); end
        run_access(1'b1, 3'b000, 32'h0000_0408, 32'h8765_4321, 2, 32'h0);
        checks++;
        if (obs_done !== 1'b1 || obs_wstrb !== 4'b1111 || obs_bwdata !== 32'h8765_4321 || obs_done_idx !== 3) begin
            errors++; $display("[TB] FAIL rst_then_sw: got done=%b wstrb=%b wdata=%h idx=%0d expected 1 1111 87654321 3",
                               obs_done, obs_wstrb, obs_bwdata, obs_done_idx);
        end
        idle_cycle();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mem_op = 3'b000; req_addr = '0; req_wdata = '0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
        test_reset();
        test_load_word();
        test_load_subword();
        test_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_in_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences every load/store leaving the MEM stage onto the single-port data bus. Takes the decoded memory access (`mem_op`, write enable, address, store data), checks alignment, generates byte strobes and replicated write data, and holds the pipeline stalled until the bus acknowledges. Returns sign- or zero-extended load data, or an address/bus error to the exception logic. Sits between the MEM stage and the data-memory/bus interface.

## Interface
- `TIMEOUT`, 255: max cycles waiting for `bus_ack` before signalling `bus_err`; 8-bit counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: MEM stage holds a load/store (`memtoreg | memwrite`).
- `req_we` in 1: 1 = store, 0 = load.
- `req_mem_op` in 3: 000 word, 001 SH, 010 SB, 100 LH, 101 LHU, 110 LB, 111 LBU.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: rt value for stores.
- `stall` out 1: freeze IF..MEM.
- `done` out 1: one-cycle pulse; access complete, pipeline advances.
- `rdata` out 32: extended load data, valid while `done`.
- `addr_err_ld` / `addr_err_st` out 1: misaligned load/store, valid while `done`.
- `bus_err` out 1: ack timeout, valid while `done`.
- `bad_vaddr` out 32: faulting `req_addr`, valid with any error.
- `bus_req` out 1; `bus_we` out 1; `bus_addr` out 32 (bits[1:0]=00); `bus_wstrb` out 4; `bus_wdata` out 32.
- `bus_rdata` in 32; `bus_ack` in 1.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, `req_valid`=0: all outputs 0, stay IDLE.
- IDLE, `req_valid`=1: `stall`=1. Latch the request.
  - Aligned: go to REQ.
  - Misaligned (word: addr[1:0]≠0; half: addr[0]≠0): go to DONE with the error flag latched; no bus cycle.
- REQ: `bus_req`=1 and `stall`=1. Bus outputs come from registers and stay stable.
  - `bus_ack`=1: capture `bus_rdata`, go to DONE.
  - Counter reaches `TIMEOUT` with no ack: set `bus_err`, drop `bus_req`, go to DONE.
- DONE: `stall`=0, `done`=1, result/error outputs driven from registers; go to IDLE unconditionally.
- Lanes are little-endian. k = addr[1:0].
  - SB: `wstrb`=0001<<k, `wdata`={4{b}}.
  - SH: `wstrb`=0011<<(2·addr[1]), `wdata`={2{h}}.
  - Word: `wstrb`=1111.
  - Loads: `wstrb`=0000. Extract the lane, sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Unknown `mem_op` (011, or store with op[2]=1) is treated as a word access.
- `req_*` are ignored outside IDLE; the latched copy is used.
- `bus_ack` outside REQ is ignored.

## Timing
- Reset values: state IDLE, counter 0, every output 0.
- Aligned access with ack in the first REQ cycle:
  - T (IDLE): `stall`=1.
  - T+1 (REQ): `bus_req`=1.
  - T+2 (DONE): `stall`=0, `done`=1.
- Each extra wait cycle adds 1 to the latency.
- Misaligned access: T stall, T+1 DONE with the error flag.
- Timeout: `bus_err` is reported in the cycle after the `TIMEOUT`-th wait cycle.
- Back-to-back: a new `req_valid` in the cycle after DONE starts a fresh access. There is no idle bubble beyond the IDLE cycle.
- `rst` in any state: next cycle is IDLE, all outputs 0, latched request discarded. `bus_req` drops one cycle after `rst`; the bus slave shares `rst` and aborts.
- `rst` coincident with `bus_ack`: reset wins; data is not captured.

## Structure
- Shared package `mem_pkg`: `mem_op` encodings (MEM_OP_WORD=000, MEM_OP_SH=001, MEM_OP_SB=010, MEM_OP_LH=100, MEM_OP_LHU=101, MEM_OP_LB=110, MEM_OP_LBU=111) and the FSM state encoding. Maindec uses the same constants.
- One sub-module `mem_lane_align` (combinational) computes:
  - the misalignment flag;
  - `wstrb` and replicated `wdata` from (op, addr[1:0], wdata);
  - extracted and extended load data from (op, addr[1:0], rdata).
- `mem_access_ctrl` holds the FSM, request latch, timeout counter and output registers.

## Test plan
- LW at 0x100, slave acks 3 cycles after `bus_req` with 0xDEADBEEF -> `stall` high 5 cycles, then `done`=1 and `rdata`=0xDEADBEEF, `bus_addr`=0x100, `wstrb`=0000.
- LB at 0x103, bus word 0x80FF_1234 -> `rdata`=0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x102 -> 0xFFFF80FF.
- SB at 0x201 with rt=0x000000AB -> `bus_addr`=0x200, `wstrb`=0010, `wdata`=0xABABABAB, `bus_we`=1. SH at 0x202 -> `wstrb`=1100.
- LW at 0x102 -> no `bus_req`; DONE with `addr_err_ld`=1, `bad_vaddr`=0x102. SH at 0x301 -> `addr_err_st`=1.
- With `TIMEOUT`=4 and no ack -> `bus_err`=1 with `done`, `bus_req` low afterwards, FSM back in IDLE.
- Assert `rst` during REQ with ack in the same cycle -> next cycle IDLE, all outputs 0, no `done`. A following SW completes normally.
